// File: rtl/spram_xw_if.sv
// spram_xw_if: requester-side bus of the byte-addressable SRAM front end.
//   req   requester -> memory  access request
//   we    requester -> memory  1 = write, 0 = read
//   sz    requester -> memory  0 = byte, 1 = half, 2 = word, 3 = reserved
//   ai    requester -> memory  byte address (AW bits)
//   vi    requester -> memory  write data, right-justified
//   rdy   memory -> requester  request accepted this cycle when req & rdy
//   vo    memory -> requester  read data, right-justified, zero-extended
//   vld   memory -> requester  vo valid, one-cycle pulse
//   err   memory -> requester  reserved-size pulse
interface spram_xw_if #(
   parameter int unsigned AW = 17
) ();
   logic          req;
   logic          we;
   logic [1:0]    sz;
   logic [AW-1:0] ai;
   logic [31:0]   vi;
   logic          rdy;
   logic [31:0]   vo;
   logic          vld;
   logic          err;

   modport master (
      output req, we, sz, ai, vi,
      input  rdy, vo, vld, err
   );

   modport slave (
      input  req, we, sz, ai, vi,
      output rdy, vo, vld, err
   );
endinterface

// File: rtl/spram_xw.sv
// spram_xw: byte/half/word access front end for a 32-bit-wide single-port RAM.
// Unaligned accesses that spill into the next word are split into two RAM
// cycles (SPLIT = 1) or truncated to the first word (SPLIT = 0).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester bus (spram_xw_if.slave): req/we/sz/ai/vi in,
//                rdy/vo/vld/err out
//   m_we         RAM write enable
//   m_bmsk       RAM byte-lane mask
//   m_ai         RAM word address
//   m_vi         RAM write data (lane-aligned)
//   m_vo         RAM read data, valid one cycle after the address
module spram_xw #(
   parameter int unsigned AW    = 17,
   parameter bit          SPLIT = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   spram_xw_if.slave     bus,
   output logic          m_we,
   output logic [3:0]    m_bmsk,
   output logic [AW-3:0] m_ai,
   output logic [31:0]   m_vi,
   input  logic [31:0]   m_vo
);

   localparam int unsigned WW = AW - 2;

   typedef enum logic {StIdle, StHi} state_e;

   state_e        r_state;
   state_e        w_state_nxt;

   // Request decode
   logic [1:0]    w_off;
   logic [3:0]    w_nmask;
   logic [7:0]    w_lanes;
   logic          w_rsvd;
   logic          w_cross;
   logic          w_rdy;
   logic          w_acc;
   logic [WW-1:0] w_word;
   logic [31:0]   w_vi_rot;

   // Second-half and read-pending state
   logic          r_live;
   logic [WW-1:0] r_hi_ai;
   logic [3:0]    r_hi_bmsk;
   logic          r_we;
   logic [31:0]   r_vi;
   logic          r_rd_hi;
   logic          r_vld;
   logic          r_split;
   logic [31:0]   r_lo;
   logic [1:0]    r_off;
   logic [1:0]    r_sz;
   logic          r_err;

   // Read result path
   logic [63:0]   w_pair;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_rd_val;

   assign w_off   = bus.ai[1:0];
   assign w_word  = bus.ai[AW-1:2];
   assign w_rsvd  = (bus.sz == 2'd3);

   always_comb begin
      w_nmask = 4'b0000;
      unique case (bus.sz)
         2'd0:    w_nmask = 4'b0001;
         2'd1:    w_nmask = 4'b0011;
         2'd2:    w_nmask = 4'b1111;
         default: w_nmask = 4'b0000;
      endcase
   end

   assign w_lanes = {4'b0000, w_nmask} << w_off;
   // With SPLIT = 0 the upper lanes are simply dropped.
   assign w_cross = SPLIT && (w_lanes[7:4] != 4'b0000);

   // r_live holds rdy low until the first edge after reset release.
   assign w_rdy   = r_live && (r_state == StIdle);
   assign w_acc   = bus.req && w_rdy;

   always_comb begin
      w_vi_rot = bus.vi;
      unique case (w_off)
         2'd0: w_vi_rot = bus.vi;
         2'd1: w_vi_rot = {bus.vi[23:0], bus.vi[31:24]};
         2'd2: w_vi_rot = {bus.vi[15:0], bus.vi[31:16]};
         2'd3: w_vi_rot = {bus.vi[7:0],  bus.vi[31:8]};
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_acc && w_cross) w_state_nxt = StHi;
         StHi:    w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // FSM: RAM-side outputs
   always_comb begin
      m_we   = 1'b0;
      m_bmsk = 4'b0000;
      m_ai   = '0;
      m_vi   = '0;
      unique case (r_state)
         StIdle: begin
            if (w_acc) begin
               m_ai   = w_word;
               m_bmsk = w_lanes[3:0];
               m_we   = bus.we && !w_rsvd;
               m_vi   = w_vi_rot;
            end
         end
         StHi: begin
            m_ai   = r_hi_ai;
            m_bmsk = r_hi_bmsk;
            m_we   = r_we;
            m_vi   = r_vi;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live    <= 1'b0;
         r_hi_ai   <= '0;
         r_hi_bmsk <= 4'b0000;
         r_we      <= 1'b0;
         r_vi      <= '0;
         r_rd_hi   <= 1'b0;
         r_vld     <= 1'b0;
         r_split   <= 1'b0;
         r_lo      <= '0;
         r_off     <= 2'd0;
         r_sz      <= 2'd0;
         r_err     <= 1'b0;
      end else begin
         r_live <= 1'b1;
         r_err  <= w_acc && w_rsvd;
         r_vld  <= 1'b0;
         if (w_acc) begin
            if (w_cross) begin
               r_hi_ai   <= w_word + {{(WW-1){1'b0}}, 1'b1};
               r_hi_bmsk <= w_lanes[7:4];
               r_we      <= bus.we;
               r_vi      <= w_vi_rot;
            end
            // Capture read shape now so a new accept in the vld cycle is harmless.
            if (!bus.we && !w_rsvd) begin
               r_off <= w_off;
               r_sz  <= bus.sz;
               if (w_cross) begin
                  r_rd_hi <= 1'b1;
               end else begin
                  r_vld   <= 1'b1;
                  r_split <= 1'b0;
               end
            end
         end
         if (r_state == StHi) begin
            r_rd_hi <= 1'b0;
            if (r_rd_hi) begin
               // m_vo now carries the first word; the second arrives next cycle.
               r_lo    <= m_vo;
               r_vld   <= 1'b1;
               r_split <= 1'b1;
            end
         end
      end
   end

   assign w_pair    = r_split ? {m_vo, r_lo} : {32'h0, m_vo};
   assign w_rd_word = 32'(w_pair >> {r_off, 3'b000});

   always_comb begin
      w_rd_val = w_rd_word;
      unique case (r_sz)
         2'd0:    w_rd_val = {24'h0, w_rd_word[7:0]};
         2'd1:    w_rd_val = {16'h0, w_rd_word[15:0]};
         default: w_rd_val = w_rd_word;
      endcase
   end

   assign bus.rdy = w_rdy;
   assign bus.vld = r_vld;
   assign bus.vo  = r_vld ? w_rd_val : 32'h0;
   assign bus.err = r_err;

endmodule

// File: tb/tb_spram_xw.sv
// tb_spram_xw: directed self-checking bench for spram_xw (AW = 17, SPLIT = 1)
// with a behavioural byte-masked RAM that returns data one cycle late.
module tb_spram_xw;

   localparam int unsigned AW = 17;

   logic          clk;
   logic          rst_n;
   logic          m_we;
   logic [3:0]    m_bmsk;
   logic [AW-3:0] m_ai;
   logic [31:0]   m_vi;
   logic [31:0]   m_vo;

   int n_tests = 0;
   int n_fail  = 0;

   spram_xw_if #(.AW(AW)) bus ();

   spram_xw #(
      .AW    (AW),
      .SPLIT (1'b1)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .m_we   (m_we),
      .m_bmsk (m_bmsk),
      .m_ai   (m_ai),
      .m_vi   (m_vi),
      .m_vo   (m_vo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit [31:0] mem [1 << (AW-2)];

   always @(posedge clk) begin
      if (m_we) begin
         for (int b = 0; b < 4; b++) begin
            if (m_bmsk[b]) mem[m_ai][8*b +: 8] <= m_vi[8*b +: 8];
         end
      end
      m_vo <= mem[m_ai];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                        input logic [31:0] v);
      bus.req = 1'b1;
      bus.we  = w;
      bus.sz  = s;
      bus.ai  = a;
      bus.vi  = v;
   endtask

   task automatic idle();
      bus.req = 1'b0;
      bus.we  = 1'b0;
      bus.sz  = 2'd0;
      bus.ai  = '0;
      bus.vi  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic seen_vld;

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) next_cyc();

      // Reset state
      @(negedge clk);
      check("rst_rdy",  32'(bus.rdy), 32'h0);
      check("rst_vld",  32'(bus.vld), 32'h0);
      check("rst_err",  32'(bus.err), 32'h0);
      check("rst_bmsk", 32'(m_bmsk),  32'h0);
      check("rst_mai",  32'(m_ai),    32'h0);
      check("rst_mwe",  32'(m_we),    32'h0);
      check("rst_vo",   bus.vo,       32'h0);
      next_cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rdy_pre", 32'(bus.rdy), 32'h0);
      next_cyc();
      @(negedge clk);
      check("rel_rdy", 32'(bus.rdy), 32'h1);

      // Aligned word write then read
      next_cyc();
      drive(1'b1, 2'd2, 17'h10, 32'hDEADBEEF);
      @(negedge clk);
      check("w1_mai",  32'(m_ai),   32'h4);
      check("w1_bmsk", 32'(m_bmsk), 32'hF);
      check("w1_mwe",  32'(m_we),   32'h1);
      check("w1_mvi",  m_vi,        32'hDEADBEEF);
      next_cyc();
      drive(1'b0, 2'd2, 17'h10, 32'h0);
      @(negedge clk);
      check("r1_mai",  32'(m_ai),   32'h4);
      check("r1_bmsk", 32'(m_bmsk), 32'hF);
      check("r1_mwe",  32'(m_we),   32'h0);
      next_cyc();
      idle();
      @(negedge clk);
      check("r1_vld",  32'(bus.vld), 32'h1);
      check("r1_vo",   bus.vo,       32'hDEADBEEF);
      check("idle_bmsk", 32'(m_bmsk), 32'h0);
      next_cyc();
      @(negedge clk);
      check("r1_vld_pulse", 32'(bus.vld), 32'h0);

      // Byte writes into a zero word, then word / half / byte reads
      next_cyc();
      drive(1'b1, 2'd0, 17'h21, 32'h000000AA);
      @(negedge clk);
      check("b1_bmsk", 32'(m_bmsk), 32'h2);
      check("b1_mvi",  m_vi,        32'h0000AA00);
      next_cyc();
      drive(1'b1, 2'd0, 17'h23, 32'h000000BB);
      @(negedge clk);
      check("b2_bmsk", 32'(m_bmsk), 32'h8);
      check("b2_mvi",  m_vi,        32'hBB000000);
      next_cyc();
      drive(1'b0, 2'd2, 17'h20, 32'h0);
      next_cyc();
      drive(1'b0, 2'd1, 17'h22, 32'h0);
      @(negedge clk);
      check("r2_vo", bus.vo, 32'hBB00AA00);
      next_cyc();
      drive(1'b0, 2'd0, 17'h21, 32'h0);
      @(negedge clk);
      check("rh_vo", bus.vo, 32'h0000BB00);
      next_cyc();
      idle();
      @(negedge clk);
      check("rb_vo", bus.vo, 32'h000000AA);

      // Split word write at 0x07, then split read back
      next_cyc();
      drive(1'b1, 2'd2, 17'h07, 32'h11223344);
      @(negedge clk);
      check("sw0_mai",  32'(m_ai),   32'h1);
      check("sw0_bmsk", 32'(m_bmsk), 32'h8);
      check("sw0_mvi",  m_vi,        32'h44112233);
      next_cyc();
      idle();
      @(negedge clk);
      check("sw1_mai",  32'(m_ai),    32'h2);
      check("sw1_bmsk", 32'(m_bmsk),  32'h7);
      check("sw1_mwe",  32'(m_we),    32'h1);
      check("sw1_rdy",  32'(bus.rdy), 32'h0);
      next_cyc();
      drive(1'b0, 2'd2, 17'h07, 32'h0);
      @(negedge clk);
      check("sr0_bmsk", 32'(m_bmsk), 32'h8);
      next_cyc();
      idle();
      @(negedge clk);
      check("sr1_vld",  32'(bus.vld), 32'h0);
      check("sr1_rdy",  32'(bus.rdy), 32'h0);
      next_cyc();
      @(negedge clk);
      check("sr2_vld", 32'(bus.vld), 32'h1);
      check("sr2_vo",  bus.vo,       32'h11223344);

      // Half read at the last byte wraps to word 0
      next_cyc();
      drive(1'b1, 2'd2, 17'h1FFFC, 32'hA1B2C3D4);
      next_cyc();
      drive(1'b1, 2'd2, 17'h00000, 32'h55667788);
      next_cyc();
      drive(1'b0, 2'd1, 17'h1FFFF, 32'h0);
      @(negedge clk);
      check("wr0_mai",  32'(m_ai),   32'h7FFF);
      check("wr0_bmsk", 32'(m_bmsk), 32'h8);
      next_cyc();
      idle();
      @(negedge clk);
      check("wr1_mai",  32'(m_ai),   32'h0);
      check("wr1_bmsk", 32'(m_bmsk), 32'h1);
      next_cyc();
      @(negedge clk);
      check("wr2_vld", 32'(bus.vld), 32'h1);
      check("wr2_vo",  bus.vo,       32'h000088A1);

      // Back-to-back reads with req held
      next_cyc();
      drive(1'b0, 2'd2, 17'h0, 32'h0);
      @(negedge clk);
      check("bb0_rdy", 32'(bus.rdy), 32'h1);
      next_cyc();
      drive(1'b0, 2'd2, 17'h4, 32'h0);
      @(negedge clk);
      check("bb1_rdy", 32'(bus.rdy), 32'h1);
      check("bb1_vo",  bus.vo,       32'h55667788);
      next_cyc();
      drive(1'b0, 2'd2, 17'h8, 32'h0);
      @(negedge clk);
      check("bb2_rdy", 32'(bus.rdy), 32'h1);
      check("bb2_vo",  bus.vo,       32'h44000000);
      next_cyc();
      idle();
      @(negedge clk);
      check("bb3_vld", 32'(bus.vld), 32'h1);
      check("bb3_vo",  bus.vo,       32'h00112233);

      // Reset during HI of a split read: no vld afterwards
      next_cyc();
      drive(1'b0, 2'd2, 17'h07, 32'h0);
      next_cyc();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      check("rhi_rdy",  32'(bus.rdy), 32'h0);
      check("rhi_bmsk", 32'(m_bmsk),  32'h0);
      check("rhi_vld",  32'(bus.vld), 32'h0);
      next_cyc();
      rst_n = 1'b1;
      seen_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen_vld = seen_vld | bus.vld;
         next_cyc();
      end
      check("rhi_no_vld", 32'(seen_vld), 32'h0);

      // Reserved size: accepted, no RAM activity, err one cycle later
      drive(1'b1, 2'd3, 17'h40, 32'hFFFFFFFF);
      @(negedge clk);
      check("rs_rdy",  32'(bus.rdy), 32'h1);
      check("rs_bmsk", 32'(m_bmsk),  32'h0);
      check("rs_mwe",  32'(m_we),    32'h0);
      check("rs_err0", 32'(bus.err), 32'h0);
      next_cyc();
      idle();
      @(negedge clk);
      check("rs_err1", 32'(bus.err), 32'h1);
      check("rs_vld1", 32'(bus.vld), 32'h0);
      next_cyc();
      @(negedge clk);
      check("rs_err2", 32'(bus.err), 32'h0);
      check("rs_vld2", 32'(bus.vld), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spram_xw.md
SPRAM_XW -- requirements
Module: spram_xw

Interface
REQ-001 SHALL have parameter AW, default 17, meaning byte-address width (memory = 2^(AW-2) 32-bit words).
REQ-002 SHALL have parameter SPLIT, default 1, meaning 1 = word-crossing accesses split into two RAM cycles, 0 = truncated to the first word.
REQ-003 SHALL have port clk, in, 1: the single clock; all flops rise on posedge clk.
REQ-004 SHALL have port rst_n, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port req, in, 1: access request.
REQ-006 SHALL have port we, in, 1: 1 = write, 0 = read.
REQ-007 SHALL have port sz, in, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 SHALL have port ai, in, AW: byte address.
REQ-009 SHALL have port vi, in, 32: write data, right-justified.
REQ-010 SHALL have port rdy, out, 1: request accepted this cycle when req&rdy.
REQ-011 SHALL have port vo, out, 32: read data, right-justified, zero-extended.
REQ-012 SHALL have port vld, out, 1: vo valid, one-cycle pulse.
REQ-013 SHALL have port err, out, 1: reserved-size pulse.
REQ-014 SHALL have port m_we, out, 1: RAM write enable.
REQ-015 SHALL have port m_bmsk, out, 4: RAM byte-lane mask.
REQ-016 SHALL have port m_ai, out, AW-2: RAM word address.
REQ-017 SHALL have port m_vi, out, 32: RAM write data.
REQ-018 SHALL have port m_vo, in, 32: RAM read data, valid one cycle after the address.

Function
REQ-019 SHALL define off=ai[1:0] and n = 1/2/4 bytes for sz = 0/1/2; lane mask L = ((1<<n)-1)<<off, 8 bits; little-endian.
REQ-020 SHALL treat an access as crossing when L[7:4]!=0.
REQ-021 SHALL, on accept, drive m_ai=ai[AW-1:2], m_bmsk=L[3:0], m_we=we, and m_vi = vi rotated left 8*off bits, all combinationally in the accept cycle.
REQ-022 SHALL run a non-crossing access in one RAM cycle with rdy held high; back-to-back accepts every cycle are legal.
REQ-023 SHALL, for a crossing access with SPLIT=1, move to state HI for one cycle: m_ai = word+1 (wrapping 2^(AW-2)-1 -> 0), m_bmsk=L[7:4], same m_we and m_vi, rdy=0; then return to IDLE.
REQ-024 SHALL, with SPLIT=0, drop lanes L[7:4] and issue no second cycle.
REQ-025 SHALL, for a read, assert vld exactly 1 cycle after the last RAM address cycle: non-crossing reads have 1-cycle latency, split reads 2 cycles.
REQ-026 SHALL compute read vo = ({hi,lo} >> 8*off) masked to n bytes, where lo = m_vo registered from the first cycle and hi = m_vo in the vld cycle; non-crossing reads use lo = m_vo direct.
REQ-027 SHALL register off, sz and split flag per read so that a new accept in the vld cycle does not corrupt vo.
REQ-028 SHALL never assert vld for writes.
REQ-029 SHALL, for sz=3: accept the request, issue m_bmsk=0 and m_we=0, pulse err the next cycle, and assert no vld.
REQ-030 SHALL drive m_bmsk=0 and m_we=0 in idle cycles (no accept, not in HI).
REQ-031 SHALL hold rdy=0 in HI; req in that cycle is not accepted and the requester holds it.
REQ-032 SHALL have FSM states IDLE and HI only; read-pending state is held in flags, not in extra FSM states.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, rdy=0, vld=0, err=0, m_we=0, m_bmsk=0, m_ai=0, vo=0 and all pending flags to 0.
REQ-034 SHALL, on rst_n deassertion, drive rdy=1 from the next clk edge.
REQ-035 SHALL, on reset in HI or with a read pending, abandon the second half and pending vld; no spurious vld after release.

Verification
REQ-036 SHALL cover: word write ai=0x10, vi=0xDEADBEEF, then word read 0x10 -> m_bmsk=1111 and m_ai=4; vld 1 cycle later with vo=0xDEADBEEF.
REQ-037 SHALL cover: byte writes 0xAA at 0x21 and 0xBB at 0x23, then word read 0x20 -> m_bmsk 0010 then 1000; vo=0xBB00AA00 from a zeroed RAM.
REQ-038 SHALL cover: SPLIT=1, word write 0x11223344 at 0x07 -> cycle 0 m_ai=1, m_bmsk=1000; cycle 1 m_ai=2, m_bmsk=0111, rdy=0; word read 0x07 -> vld at +2 cycles with vo=0x11223344.
REQ-039 SHALL cover: half read at last byte 2^AW-1 -> second cycle m_ai=0, m_bmsk=0001; result combines byte 3 of the last word with byte 0 of word 0.
REQ-040 SHALL cover: back-to-back reads at 0x0, 0x4, 0x8 with req held -> rdy stays 1; three consecutive vld pulses carry the correct data.
REQ-041 SHALL cover: rst_n low during HI of a split read, and sz=3 request -> no vld after release; err pulses once, 1 cycle after the sz=3 accept.
